// File: rtl/frac_mul_pkg.sv
// Shared types and sizing helpers for the sequential fraction multiplier.
// No logic; no latency; no flow control.
// The saturation option is FRAC_MUL_SAT_EN; it is used by fraction_multiplier_n.
package frac_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int W_DEF = 8;

    // The iteration counter must hold 0..W-1, so at least one bit is kept for W=2.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic int prod_width(input int w);
        return 2 * w - 1;
    endfunction

endpackage

// File: rtl/frac_mul_addsub.sv
// (W+1)-bit adder/subtractor for the partial-product accumulator.
// Combinational, so it adds no latency; it has no flow control.
// One extra guard bit keeps every intermediate sum in range.
module frac_mul_addsub
    import frac_mul_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W:0] i_a,
    input  logic [W:0] i_b,
    input  logic       i_sub,
    output logic [W:0] o_sum
);

    assign o_sum = i_sub ? (i_a - i_b) : (i_a + i_b);

endmodule

// File: rtl/fraction_multiplier_n.sv
// W-bit signed fraction multiplier: one add/sub-and-shift step per clock, giving a (2W-1)-bit product.
// W+2 cycles from start to start. St is dropped while Busy is high; nothing is queued.
// When FRAC_MUL_SAT_EN is defined, -1 x -1 saturates to the largest positive fraction.
module fraction_multiplier_n
    import frac_mul_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     St,
    input  logic [W-1:0]             Mplier,
    input  logic [W-1:0]             Mcand,
    output logic [prod_width(W)-1:0] Product,
    output logic                     Ovf,
    output logic                     Busy,
    output logic                     Done
);

    localparam int CW = cnt_width(W);
    localparam int PW = prod_width(W);
    localparam logic [W-1:0] NEG_ONE = {1'b1, {(W-1){1'b0}}};

    state_t          r_state;
    logic [W:0]      r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_c;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf_pend;

    logic            w_last;
    logic [W:0]      w_sum;
    logic [W:0]      w_acc;
    logic [W:0]      w_a_nxt;
    logic [W-1:0]    w_b_nxt;
    logic [PW-1:0]   w_prod;

    // The last step weighs the multiplier sign bit as -1, so that step subtracts.
    assign w_last = (r_cnt == CW'(W - 1));

    frac_mul_addsub #(.W(W)) u_addsub (
        .i_a   (r_a),
        .i_b   ({r_c[W-1], r_c}),
        .i_sub (w_last),
        .o_sum (w_sum)
    );

    assign w_acc   = r_b[0] ? w_sum : r_a;
    assign w_a_nxt = {w_acc[W], w_acc[W:1]};
    assign w_b_nxt = {w_acc[0], r_b[W-1:1]};

`ifdef FRAC_MUL_SAT_EN
    assign w_prod = r_ovf_pend ? {1'b0, {(PW-1){1'b1}}} : {w_a_nxt[W-2:0], w_b_nxt};
`else
    assign w_prod = {w_a_nxt[W-2:0], w_b_nxt};
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            Product    <= '0;
            Ovf        <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (St) begin
                        r_state    <= RUN;
                        r_a        <= '0;
                        r_b        <= Mplier;
                        r_c        <= Mcand;
                        r_cnt      <= '0;
                        r_ovf_pend <= (Mplier == NEG_ONE) && (Mcand == NEG_ONE);
                        Busy       <= 1'b1;
                    end
                end
                RUN: begin
                    r_a   <= w_a_nxt;
                    r_b   <= w_b_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= DONE;
                        Product <= w_prod;
                        Ovf     <= r_ovf_pend;
                        Done    <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fraction_multiplier_n.md
# fraction_multiplier_n

Parametrised sequential two's-complement fraction multiplier: multiplies a W-bit signed fraction multiplier by a W-bit signed fraction multiplicand using one add/subtract-and-shift step per clock, and returns a (2W-1)-bit signed fraction product. It is the next-generation multiplier for the datapath library. Over the fixed 4-bit version it adds:
- width parameter W;
- synchronous reset;
- registered, held product;
- Busy status;
- detection of the −1 × −1 overflow case, with optional saturation.

## Interface
Parameters:
- W, 8, operand width in bits; legal range 2..32.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- St  in  1  start request; sampled only in IDLE.
- Mplier  in  W  multiplier, signed fraction (sign bit is bit W-1).
- Mcand  in  W  multiplicand, signed fraction.
- Product  out  2W-1  registered product fraction; reset 0.
- Ovf  out  1  registered; set when both operands were −1 (1000…0); reset 0.
- Busy  out  1  high in RUN and DONE; reset 0.
- Done  out  1  one-cycle completion pulse (high in DONE state); reset 0.

## Operation
States and transitions:
- IDLE: if St=1, go to RUN.
- RUN: repeat the step for W iterations, then go to DONE.
- DONE: go to IDLE unconditionally.

Datapath:
- IDLE→RUN edge:
  - A (W+1 bits, sign guard) ← 0.
  - B ← Mplier.
  - C ← Mcand.
  - count ← 0.
  - Ovf_pending ← (Mplier == 1000…0 && Mcand == 1000…0).
- RUN step, iterations 0..W-2: if B[0]=1, A ← A + sext(C); then arithmetic shift right of {A,B} by 1.
- RUN step, final iteration (count = W-1): if B[0]=1 (the multiplier sign bit), A ← A − sext(C); then the same shift.
- RUN→DONE edge: Product ← {A,B}[2W-2:0] (the integer product modulo 2^(2W-1)); Ovf ← Ovf_pending.
- Product and Ovf hold their values until the next RUN→DONE edge. They are not disturbed while a new operation runs.

Rules:
- Mplier and Mcand are sampled only on the start edge. Later input changes are ignored.
- St is ignored in RUN and DONE. There is no queueing; a pulse is lost if Busy=1.
- The add/sub width is W+1 bits, so intermediate results never overflow. Only the final −1 × −1 result, +1.0, is unrepresentable.

## Timing
- St high before rising edge k (state IDLE) → RUN from edge k; Busy=1 in the cycle after edge k.
- Iterations occur on edges k+1 … k+W. Product and Ovf are updated on edge k+W. Done=1 for exactly the cycle after edge k+W.
- Edge k+W+1 returns to IDLE; Busy=0 and Done=0. The earliest next start is St sampled on edge k+W+2.
- Start-to-start throughput is W+2 cycles.
- RST=1 on any edge, including mid-RUN:
  - state ← IDLE;
  - A, B, C, count, Product, Ovf, Busy, Done ← 0;
  - St on that edge is ignored.
- RST takes priority over St.

## Configuration
- FRAC_MUL_SAT_EN defined: when Ovf_pending=1, the RUN→DONE edge writes Product ← 0111…1 (2^(2W-2)−1, the largest positive fraction) instead of the wrapped value. Ovf is still set.
- Undefined: Product takes the wrapped value 1000…0, which reads as −1.0. Ovf is set.

## Structure
- Package frac_mul_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - count-width function $clog2(W);
  - localparam for the product width 2W-1.
- Sub-module frac_mul_addsub: a (W+1)-bit adder/subtractor with inputs A, sext(C) and a sub select. The top level instantiates it once.
- All FSM, shift and output registers live in the top level.

## Test plan
1. W=4, Mplier=0100 (0.5), Mcand=0110 (0.75), St for one cycle → Done pulses exactly 5 cycles after the start edge; Product=0x18; Ovf=0.
2. W=4, Mplier=1100 (−0.5), Mcand=0110 → Product=0x68; Ovf=0. Then Mplier=0110, Mcand=1100 → Product=0x68.
3. W=4, Mplier=1000, Mcand=1000 → Ovf=1; Product=0x40 without FRAC_MUL_SAT_EN; Product=0x3F with it defined.
4. W=8, Mplier=0x80, Mcand=0x7F → Product=0x4080; Done 9 cycles after start; Busy high for 9 cycles.
5. Assert RST at the third RUN cycle, with St held high throughout → next cycle Busy=0, Done=0, Product=0. The new start is taken on the first edge with RST low, and the result is correct.
6. Pulse St while Busy=1 and change the inputs mid-RUN → the pulse is ignored, Product reflects only the operands sampled on the start edge, and exactly one Done pulse occurs.
